lif_spike_encoder: RTL
======================

// Module: lif_spike_encoder
// PURPOSE
//  Rate encoder that produces the spike_in train for lif_neuron. Accepts one intensity sample per
//  window over a valid/ready handshake, then emits a deterministic, evenly spaced train of 1-cycle
//  spikes for WIN_CYCLES cycles. Spike count = floor(intensity*WIN_CYCLES/2^DATA_W).
//  Sits between the sample source and the neuron array; replaces bench-driven spike stimulus.
// PARAMETERS
//  DATA_W      8    intensity width; also the phase-accumulator width
//  WIN_CYCLES  256  encode-window length in clk cycles (>=1)
//  GAP_CYCLES  4    forced-silence cycles after each window (0 = none)
//  CNT_W       9    spike_count width (>= clog2(WIN_CYCLES+1))
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-low (0 = reset)
//  in_valid     in   1       intensity sample valid
//  in_data      in   DATA_W  intensity (0 = silent, 2^DATA_W-1 = max rate)
//  in_ready     out  1       encoder can accept a sample
//  stop         in   1       synchronous abort of the current window/gap
//  spike_out    out  1       spike train to neuron spike_in (registered)
//  busy         out  1       high in ENCODE or GAP
//  window_done  out  1       1-cycle pulse at end of a complete window
//  spike_count  out  CNT_W   spikes emitted in last completed window; held until next completion
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; acc, cycle count, spike tally, spike_out, window_done,
//   spike_count all 0; busy=0; in_ready=1 once reset released.
//  States: IDLE -> ENCODE -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//  in_ready = (state==IDLE) && !stop (combinational). Accept = in_valid && in_ready at an edge;
//   in_data latched, acc<=0, cyc<=0, tally<=0, state<=ENCODE.
//  ENCODE, each edge: {carry,sum}=acc+latched (DATA_W+1 bits); acc<=sum; spike_out<=carry;
//   tally+=carry; cyc++. At the edge where cyc==WIN_CYCLES-1: spike_count<=tally+carry,
//   window_done<=1, state<=GAP (or IDLE).
//  Latency: first possible spike_out high 1 cycle after the first ENCODE edge; last window spike
//   is visible in the first GAP/IDLE cycle. spike_out never high for >1 cycle unless
//   intensity*2 > 2^DATA_W (adjacent carries allowed).
//  GAP: spike_out<=0; counts GAP_CYCLES edges then IDLE. IDLE: spike_out<=0, window_done<=0.
//  window_done is high exactly one cycle per completed window; never on abort.
//  stop (any state != IDLE): next edge state<=IDLE, spike_out<=0, spike_count unchanged,
//   no window_done. stop in IDLE: blocks accept that cycle only.
//  in_data changes after accept have no effect on the running window.
//  Intensity 0: zero spikes, window still runs and pulses window_done with spike_count=0.
//  Reset asserted mid-window: immediate clear to reset values, no done pulse.
//  Back-to-back samples: minimum 1 IDLE cycle between windows (GAP_CYCLES+1 total).
// STRUCTURE
//  Shared package lif_pkg: state encoding (IDLE/ENCODE/GAP), default DATA_W, clog2 helper.
//  Sub-module lif_rate_accum: phase accumulator (clear, enable, increment) -> carry pulse;
//   top holds FSM, window/gap counters, tally and handshake.
// TESTING
//  1 Reset: hold reset=0 with in_valid=1 -> in_ready, spike_out, busy, window_done, spike_count
//    all 0 during reset; in_ready=1 the cycle after release.
//  2 DATA_W=8, WIN=256, intensity 128 -> spikes on every 2nd cycle (first at 2nd ENCODE cycle),
//    128 spikes total, window_done once, spike_count=128.
//  3 intensity 64 -> one spike every 4 cycles, spike_count=64; intensity 0 -> no spikes,
//    spike_count=0; intensity 255 -> spike_count=255, only 1 non-spike cycle in window.
//  4 Back-to-back valid with 64 then 32, GAP=4 -> second accept exactly 5 cycles after first
//    window_done; in_ready=0 throughout ENCODE/GAP; spike_count 64 then 32.
//  5 stop asserted at cycle 100 of a 128-intensity window -> IDLE next cycle, spike_out=0,
//    no window_done, spike_count retains prior value.
//  6 reset pulsed low at cycle 50 of window -> all outputs 0 asynchronously; new sample after
//    release encodes a full correct window.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF spike encoder: FSM state encoding,
// default widths and a constant-evaluable clog2 helper.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_GAP    = 2'd2
  } lif_state_e;

  localparam int DEFAULT_DATA_W = 8;

  function automatic int clog2(input int unsigned v);
    int unsigned p;
    int          r;
    p = 1;
    r = 0;
    while (p < v) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lif_rate_accum.sv
// Phase accumulator for rate encoding: adds the latched intensity each enabled
// cycle; the carry out of the top bit is the spike for that cycle.
module lif_rate_accum
  import lif_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] inc,
  output logic              carry
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc};
    carry = en & sum[DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/lif_spike_encoder.sv
// Rate encoder: accepts one intensity per window and emits an evenly spaced
// train of 1-cycle spikes for WIN_CYCLES cycles, followed by a forced gap.
module lif_spike_encoder
  import lif_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int WIN_CYCLES = 256,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_W      = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              stop,
  output logic              spike_out,
  output logic              busy,
  output logic              window_done,
  output logic [CNT_W-1:0]  spike_count
);

  localparam int CYC_W = (clog2(WIN_CYCLES) < 1) ? 1 : clog2(WIN_CYCLES);
  localparam int GAP_W = (clog2(GAP_CYCLES) < 1) ? 1 : clog2(GAP_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WIN_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  lif_state_e        state_q, state_d;
  logic [DATA_W-1:0] data_q;
  logic [CYC_W-1:0]  cyc_q;
  logic [GAP_W-1:0]  gap_q;
  logic [CNT_W-1:0]  tally_q;
  logic              ready_en_q;
  logic              accept;
  logic              last_cyc;
  logic              gap_last;
  logic              acc_en;
  logic              carry;

  // ready_en_q keeps in_ready low during reset and until the first edge after release
  assign in_ready = (state_q == ST_IDLE) && !stop && ready_en_q;
  assign busy     = (state_q != ST_IDLE);
  assign accept   = in_valid && in_ready;
  assign last_cyc = (state_q == ST_ENCODE) && (cyc_q == CYC_LAST);
  assign gap_last = (state_q == ST_GAP) && (gap_q == GAP_LAST);
  assign acc_en   = (state_q == ST_ENCODE) && !stop;

  lif_rate_accum #(
    .DATA_W (DATA_W)
  ) u_accum (
    .clk   (clk),
    .rst_n (reset),
    .clear (accept),
    .en    (acc_en),
    .inc   (data_q),
    .carry (carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_ENCODE;
      end
      ST_ENCODE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (last_cyc) begin
          state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        if (stop || gap_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q      <= '0;
      cyc_q       <= '0;
      gap_q       <= '0;
      tally_q     <= '0;
      spike_out   <= 1'b0;
      window_done <= 1'b0;
      spike_count <= '0;
      ready_en_q  <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      spike_out   <= 1'b0;
      window_done <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= in_data;
            cyc_q   <= '0;
            tally_q <= '0;
          end
        end
        ST_ENCODE: begin
          if (!stop) begin
            spike_out <= carry;
            tally_q   <= tally_q + CNT_W'(carry);
            cyc_q     <= cyc_q + CYC_W'(1);
            if (last_cyc) begin
              spike_count <= tally_q + CNT_W'(carry);
              window_done <= 1'b1;
              gap_q       <= '0;
            end
          end
        end
        ST_GAP: begin
          gap_q <= gap_q + GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
